// File: rtl/fdd_cache_pkg.sv
// Shared types and helpers for the single-track floppy cache.
package fdd_cache_pkg;

  localparam int SECTORS     = 13;
  localparam int SEC_BYTES   = 512;
  localparam int TRACK_BYTES = SECTORS * SEC_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_XFER,
    ST_RD_REQ,
    ST_RD_XFER
  } state_e;

  // Image sector address of (track, sector); 63*13+12 fits in 10 bits.
  function automatic logic [9:0] calc_lba(input logic [9:0] trk, input logic [9:0] sec);
    return trk * 10'd13 + sec;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fdd_track_ram.sv
// True dual-port byte RAM holding one track, registered read on both ports.
module fdd_track_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_din_i,
  output logic [DW-1:0] a_dout_o,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_din_i,
  output logic [DW-1:0] b_dout_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_sys) begin
    if (a_we_i) mem_q[a_addr_i] <= a_din_i;
    if (b_we_i) mem_q[b_addr_i] <= b_din_i;
    a_dout_o <= mem_q[a_addr_i];
    b_dout_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/fdd_track_cache.sv
// Write-back cache of one floppy track between the disk controller and the
// SD block interface; loads on track change/mount, flushes dirty sectors first.
module fdd_track_cache
  import fdd_cache_pkg::*;
#(
  parameter int SECTORS = 13,
  parameter int TRK_W   = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [TRK_W-1:0] track,
  input  logic             img_mounted,
  input  logic             img_size_nz,
  input  logic             img_readonly,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic [8:0]       sd_buff_addr,
  input  logic [7:0]       sd_buff_dout,
  input  logic             sd_buff_wr,
  output logic [7:0]       sd_buff_din,
  input  logic [13:0]      fd_track_addr,
  input  logic [7:0]       fd_data_do,
  input  logic             fd_write_disk,
  output logic [7:0]       fd_data_in,
  output logic             cpu_wait,
  output logic             valid
);

  state_e             state_q, state_d;
  logic [TRK_W-1:0]   cur_track_q, cur_track_d;
  logic [3:0]         sec_q, sec_d;
  logic [SECTORS-1:0] dirty_q, dirty_d, dirty_set, dirty_clr;
  logic               valid_q, valid_d;
  logic               pending_q, pending_d;
  logic               mount_q, mount_d;
  logic               mount_evt, clr_en, mount_clr;
  logic [3:0]         fd_sec;
  logic               fd_we, sd_we;

  assign fd_sec    = fd_track_addr[12:9];
  assign fd_we     = fd_write_disk && !fd_track_addr[13] && (fd_sec < 4'(SECTORS)) && valid_q;
  assign sd_we     = sd_buff_wr && sd_ack && (state_q == ST_RD_XFER);
  // A mount arriving mid-transfer is remembered and handled back in IDLE.
  assign mount_evt = img_mounted || mount_q;

  genvar gi;
  generate
    for (gi = 0; gi < SECTORS; gi++) begin : g_dirty
      assign dirty_set[gi] = fd_we && !img_readonly && (fd_sec == 4'(gi));
      assign dirty_clr[gi] = clr_en && (sec_q == 4'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    sec_d       = sec_q;
    valid_d     = valid_q;
    pending_d   = pending_q;
    mount_d     = mount_q || img_mounted;
    clr_en      = 1'b0;
    mount_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mount_d = 1'b0;
        if (mount_evt) begin
          mount_clr = 1'b1;
          valid_d   = 1'b0;
          pending_d = 1'b1;
        end else if (pending_q || (track != cur_track_q)) begin
          if ((dirty_q != '0) && valid_q) begin
            sec_d   = lowest_set(16'(dirty_q));
            state_d = ST_WR_REQ;
          end else if (img_size_nz) begin
            sec_d       = 4'd0;
            cur_track_d = track;
            state_d     = ST_RD_REQ;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      ST_WR_REQ: begin
        if (sd_ack) begin
          clr_en  = 1'b1;
          state_d = ST_WR_XFER;
        end
      end
      ST_WR_XFER: begin
        if (!sd_ack) begin
          if (dirty_q != '0) begin
            sec_d   = lowest_set(16'(dirty_q));
            state_d = ST_WR_REQ;
          end else if (img_size_nz) begin
            sec_d       = 4'd0;
            cur_track_d = track;
            state_d     = ST_RD_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_REQ: begin
        if (sd_ack) state_d = ST_RD_XFER;
      end
      ST_RD_XFER: begin
        if (!sd_ack) begin
          if (sec_q == 4'(SECTORS - 1)) begin
            valid_d   = 1'b1;
            pending_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            sec_d   = sec_q + 4'd1;
            state_d = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Set after clear: a sector written during its own flush is flushed again.
    dirty_d = mount_clr ? '0 : ((dirty_q & ~dirty_clr) | dirty_set);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_track_q <= '0;
      sec_q       <= 4'd0;
      dirty_q     <= '0;
      valid_q     <= 1'b0;
      pending_q   <= 1'b1;
      mount_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_track_q <= cur_track_d;
      sec_q       <= sec_d;
      dirty_q     <= dirty_d;
      valid_q     <= valid_d;
      pending_q   <= pending_d;
      mount_q     <= mount_d;
    end
  end

  assign sd_lba   = {22'd0, calc_lba(10'(cur_track_q), 10'(sec_q))};
  assign sd_rd    = (state_q == ST_RD_REQ);
  assign sd_wr    = (state_q == ST_WR_REQ);
  assign cpu_wait = (state_q != ST_IDLE);
  assign valid    = valid_q;

  fdd_track_ram #(.AW(13), .DW(8)) u_ram (
    .clk_sys  (clk_sys),
    .a_we_i   (sd_we),
    .a_addr_i ({sec_q, sd_buff_addr}),
    .a_din_i  (sd_buff_dout),
    .a_dout_o (sd_buff_din),
    .b_we_i   (fd_we),
    .b_addr_i (fd_track_addr[12:0]),
    .b_din_i  (fd_data_do),
    .b_dout_o (fd_data_in)
  );

endmodule

// File: tb/tb_fdd_track_cache.sv
// Scoreboard bench: expected SD requests are queued per scenario and
// matched against the requests the cache issues to a simple SD model.
module tb_fdd_track_cache;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  track = 6'd0;
  logic        img_mounted = 1'b0;
  logic        img_size_nz = 1'b0;
  logic        img_readonly = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = 9'd0;
  logic [7:0]  sd_buff_dout = 8'd0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;
  logic [13:0] fd_track_addr = 14'd0;
  logic [7:0]  fd_data_do = 8'd0;
  logic        fd_write_disk = 1'b0;
  logic [7:0]  fd_data_in;
  logic        cpu_wait, valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_wr;
    int lba;
    int sec;
  } req_t;

  req_t       exp_q[$];
  logic [7:0] wb_first[$];
  logic [7:0] model_buf [0:6655];

  fdd_track_cache #(.SECTORS(13), .TRK_W(6)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .img_mounted(img_mounted),
    .img_size_nz(img_size_nz), .img_readonly(img_readonly), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .fd_track_addr(fd_track_addr), .fd_data_do(fd_data_do), .fd_write_disk(fd_write_disk),
    .fd_data_in(fd_data_in), .cpu_wait(cpu_wait), .valid(valid)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] img_byte(input int lba, input int off);
    int v;
    v = lba * 37 + off * 5 + (off >>> 7);
    return v[7:0];
  endfunction

  task automatic push_reads(input int trk, input int first, input int last);
    for (int s = first; s <= last; s++) exp_q.push_back('{1'b0, trk * 13 + s, s});
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (sd_rd || sd_wr) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic serve_all();
    req_t e;
    bit   got;
    int   bad;
    while (exp_q.size() > 0) begin
      wait_req(got);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL req_timeout: no request seen, required %s lba %0d", e.is_wr ? "wr" : "rd", e.lba);
        exp_q.delete();
        return;
      end
      checks++;
      if (sd_wr !== e.is_wr || sd_rd !== !e.is_wr || sd_lba !== 32'(e.lba) || cpu_wait !== 1'b1) begin
        errors++;
        $display("FAIL req_match: got rd=%b wr=%b lba=%0d wait=%b, required wr=%0d lba=%0d wait=1",
                 sd_rd, sd_wr, sd_lba, cpu_wait, e.is_wr, e.lba);
      end
      $display("xfer %s lba %0d sector %0d", e.is_wr ? "wr" : "rd", e.lba, e.sec);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      if (!e.is_wr) begin
        for (int i = 0; i < 512; i++) begin
          sd_buff_addr = 9'(i);
          sd_buff_dout = img_byte(e.lba, i);
          sd_buff_wr   = 1'b1;
          model_buf[e.sec * 512 + i] = img_byte(e.lba, i);
          @(negedge clk_sys);
        end
        sd_buff_wr = 1'b0;
      end else begin
        bad = 0;
        for (int i = 0; i <= 512; i++) begin
          if (i > 0) begin
            if (sd_buff_din !== model_buf[e.sec * 512 + i - 1]) bad++;
            if (i == 1) wb_first.push_back(sd_buff_din);
          end
          if (i < 512) sd_buff_addr = 9'(i);
          @(negedge clk_sys);
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL wb_data lba %0d: %0d bytes differ, required 0", e.lba, bad);
        end
      end
      sd_ack = 1'b0;
      @(negedge clk_sys);
    end
  endtask

  task automatic check_quiet(input int cycles, input bit exp_valid, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr || cpu_wait) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_quiet: %0d busy cycles, required 0", name, bad);
    end
    checks++;
    if (valid !== exp_valid) begin
      errors++;
      $display("FAIL %s_valid: got %b required %b", name, valid, exp_valid);
    end
  endtask

  task automatic fd_write(input logic [13:0] a, input logic [7:0] d);
    fd_track_addr = a;
    fd_data_do    = d;
    fd_write_disk = 1'b1;
    @(negedge clk_sys);
    fd_write_disk = 1'b0;
  endtask

  task automatic fd_check(input logic [13:0] a, input logic [7:0] exp, input string name);
    fd_track_addr = a;
    @(negedge clk_sys);
    checks++;
    if (fd_data_in !== exp) begin
      errors++;
      $display("FAIL %s: addr %h got %h required %h", name, a, fd_data_in, exp);
    end
  endtask

  task automatic check_dirty(input logic [12:0] exp, input string name);
    checks++;
    if (dut.dirty_q !== exp) begin
      errors++;
      $display("FAIL %s: dirty got %h required %h", name, dut.dirty_q, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || cpu_wait !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b wait=%b valid=%b required all 0", sd_rd, sd_wr, cpu_wait, valid);
    end
    check_dirty(13'h0000, "reset_dirty");
    reset = 1'b0;
    check_quiet(10, 1'b0, "reset_empty");
  endtask

  task automatic test_initial_load();
    img_size_nz = 1'b1;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    push_reads(0, 0, 12);
    serve_all();
    check_quiet(10, 1'b1, "load0");
    fd_check(14'h19FF, img_byte(12, 511), "fd_last_byte");
    fd_check(14'h0000, img_byte(0, 0), "fd_first_byte");
    fd_check(14'h0A37, img_byte(5, 9'h037), "fd_mid_byte");
  endtask

  task automatic test_track_change();
    track = 6'd5;
    @(negedge clk_sys);
    checks++;
    if (sd_rd !== 1'b1 || cpu_wait !== 1'b1 || sd_lba !== 32'd65) begin
      errors++;
      $display("FAIL req_latency: rd=%b wait=%b lba=%0d required rd=1 wait=1 lba=65", sd_rd, cpu_wait, sd_lba);
    end
    push_reads(5, 0, 12);
    serve_all();
    check_quiet(10, 1'b1, "trk5");
  endtask

  task automatic test_dirty_writeback();
    fd_write(14'h0200, 8'hA5);
    fd_write(14'h1800, 8'hA5);
    fd_write(14'h1B00, 8'h5A);
    model_buf[16'h0200] = 8'hA5;
    model_buf[16'h1800] = 8'hA5;
    @(negedge clk_sys);
    check_dirty(13'h1002, "dirty_bits");
    wb_first.delete();
    exp_q.push_back('{1'b1, 66, 1});
    exp_q.push_back('{1'b1, 77, 12});
    push_reads(6, 0, 12);
    track = 6'd6;
    serve_all();
    checks++;
    if (wb_first.size() != 2 || wb_first[0] !== 8'hA5 || wb_first[1] !== 8'hA5) begin
      errors++;
      $display("FAIL wb_byte0: got %0d sectors, required 2 sectors starting with a5", wb_first.size());
    end
    check_dirty(13'h0000, "dirty_flushed");
    check_quiet(10, 1'b1, "trk6");
    fd_check(14'h0200, img_byte(79, 0), "fd_after_flush");
  endtask

  task automatic test_readonly();
    img_readonly = 1'b1;
    fd_write(14'h0200, 8'hA5);
    fd_write(14'h1B00, 8'h5A);
    @(negedge clk_sys);
    check_dirty(13'h0000, "ro_dirty");
    fd_check(14'h0200, 8'hA5, "ro_ram_write");
    push_reads(7, 0, 12);
    track = 6'd7;
    serve_all();
    check_quiet(10, 1'b1, "trk7");
    img_readonly = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bit got;
    track = 6'd8;
    push_reads(8, 0, 5);
    serve_all();
    wait_req(got);
    checks++;
    if (!got || sd_rd !== 1'b1 || sd_lba !== 32'd110) begin
      errors++;
      $display("FAIL mid_req: got=%b rd=%b lba=%0d required rd=1 lba=110", got, sd_rd, sd_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      sd_buff_addr = 9'(i);
      sd_buff_dout = 8'hEE;
      sd_buff_wr   = 1'b1;
      @(negedge clk_sys);
    end
    checks++;
    if (valid !== 1'b1 || cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: valid=%b wait=%b required 1 1", valid, cpu_wait);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (sd_rd !== 1'b0 || cpu_wait !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rd=%b wait=%b valid=%b required 0 0 0", sd_rd, cpu_wait, valid);
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    push_reads(8, 0, 12);
    serve_all();
    check_quiet(10, 1'b1, "reload8");
    fd_check(14'h0C00, img_byte(110, 0), "fd_reload");
  endtask

  task automatic test_mount_empty();
    img_size_nz = 1'b0;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    check_quiet(40, 1'b0, "mount_empty");
  endtask

  initial begin
    test_reset();
    test_initial_load();
    test_track_change();
    test_dirty_writeback();
    test_readonly();
    test_reset_mid_load();
    test_mount_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
